// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch / next-PC stage: FSM state encoding,
// reset defaults and the control bundle handed to the next-PC selector.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'h11;

  // Branch/jump decode plus the datapath flags that qualify the branches.
  typedef struct packed {
    logic jump_reg;
    logic jump;
    logic branch_z;
    logic branch_nz;
    logic z_flag;
    logic nz_flag;
  } pc_ctrl_t;

  function automatic logic [31:0] sext26(input logic [25:0] offset);
    return {{6{offset[25]}}, offset};
  endfunction

endpackage

// File: rtl/ifetch_unit_next_pc_sel.sv
// Next-PC selection: sequential, jump, register and branch targets resolved by
// fixed priority, result forced word-aligned.
module ifetch_unit_next_pc_sel
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] jump_offset,
  input  logic [31:0] reg_target,
  input  logic [31:0] branch_offset,
  input  pc_ctrl_t    ctrl,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic [31:0] target;

  // All adds are modulo 2^32; the carry-out simply falls off.
  assign jump_target   = pc_plus4 + sext26(jump_offset);
  assign branch_target = pc_plus4 + branch_offset;
  assign branch_taken  = (ctrl.branch_z && ctrl.z_flag) || (ctrl.branch_nz && ctrl.nz_flag);

  // NOTE: default assigned first so every path drives target and no latch is inferred.
  always_comb begin
    target = pc_plus4;
    if (ctrl.jump_reg)  target = reg_target;
    else if (ctrl.jump) target = jump_target;
    else if (branch_taken) target = branch_target;
  end

  // Misaligned targets are silently truncated to a word boundary.
  assign next_pc = target & ~32'h0000_0003;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC/instruction registers, FETCH/EXEC/HALT sequencing and the
// instruction-memory request/ready handshake.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic [31:0] imemRdata,
  input  logic        imemReady,
  input  logic        branchZ,
  input  logic        branchNZ,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic        zFlag,
  input  logic        nzFlag,
  input  logic [31:0] extendedImm,
  input  logic [31:0] registerS1,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pcPlus4,
  output logic        endProgram
);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         accept;
  pc_ctrl_t     ctrl;

  assign accept  = (state == ST_FETCH) && imemReady;
  assign pcPlus4 = pc + 32'd4;
  assign imemAddr = pc;

  assign ctrl = '{jump_reg:  jumpReg,
                  jump:      jump,
                  branch_z:  branchZ,
                  branch_nz: branchNZ,
                  z_flag:    zFlag,
                  nz_flag:   nzFlag};

  ifetch_unit_next_pc_sel u_next_pc_sel (
    .pc_plus4      (pcPlus4),
    .jump_offset   (instr[25:0]),
    .reg_target    (registerS1),
    .branch_offset (extendedImm),
    .ctrl          (ctrl),
    .next_pc       (next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    imemReq    = 1'b0;
    instrValid = 1'b0;
    endProgram = 1'b0;
    case (state)
      ST_FETCH: begin
        // Gated by reset so an outstanding request vanishes the moment reset asserts.
        imemReq = reset;
        if (imemReady)
          state_next = (imemRdata[31:26] == HALT_OPCODE) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        instrValid = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        endProgram = 1'b1;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (accept)            instr <= imemRdata;
      if (state == ST_EXEC)  pc    <= next_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level model of the fetch stage.
module tb_ifetch_unit;

  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_HALT  = 2;
  localparam logic [5:0] HALT_OP = 6'h11;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic [31:0] imemRdata;
  logic        imemReady;
  logic        branchZ, branchNZ, jump, jumpReg, zFlag, nzFlag;
  logic [31:0] extendedImm, registerS1;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] pcPlus4;
  logic        endProgram;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_phase;

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imemAddr    (imemAddr),
    .imemReq     (imemReq),
    .imemRdata   (imemRdata),
    .imemReady   (imemReady),
    .branchZ     (branchZ),
    .branchNZ    (branchNZ),
    .jump        (jump),
    .jumpReg     (jumpReg),
    .zFlag       (zFlag),
    .nzFlag      (nzFlag),
    .extendedImm (extendedImm),
    .registerS1  (registerS1),
    .instr       (instr),
    .instrValid  (instrValid),
    .pcPlus4     (pcPlus4),
    .endProgram  (endProgram)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_phase = PH_FETCH;
  endtask

  // Target rules stated directly: priority jr > j > beqz > bnez > sequential, word aligned.
  function automatic logic [31:0] ref_next_pc();
    logic [31:0] seq, t;
    seq = m_pc + 32'd4;
    if (jumpReg)                t = registerS1;
    else if (jump)              t = seq + {{6{m_instr[25]}}, m_instr[25:0]};
    else if (branchZ && zFlag)  t = seq + extendedImm;
    else if (branchNZ && nzFlag) t = seq + extendedImm;
    else                        t = seq;
    return {t[31:2], 2'b00};
  endfunction

  // One clock: compare all outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    @(negedge clk);
    check("imemAddr",   imemAddr,   m_pc);
    check("imemReq",    {31'b0, imemReq},    {31'b0, reset && (m_phase == PH_FETCH)});
    check("instrValid", {31'b0, instrValid}, {31'b0, m_phase == PH_EXEC});
    check("endProgram", {31'b0, endProgram}, {31'b0, m_phase == PH_HALT});
    check("pcPlus4",    pcPlus4,    m_pc + 32'd4);
    check("instr",      instr,      m_instr);
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      case (m_phase)
        PH_FETCH: if (imemReady) begin
          m_instr = imemRdata;
          m_phase = (imemRdata[31:26] == HALT_OP) ? PH_HALT : PH_EXEC;
        end
        PH_EXEC: begin
          m_pc    = ref_next_pc();
          m_phase = PH_FETCH;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic clear_ctrl();
    branchZ = 1'b0; branchNZ = 1'b0; jump = 1'b0; jumpReg = 1'b0;
    zFlag = 1'b0; nzFlag = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
  endtask

  // From FETCH: fetch a plain word, then jr to the requested address.
  task automatic goto_pc(input logic [31:0] target);
    clear_ctrl();
    imemReady = 1'b1;
    imemRdata = 32'h2000_0000;
    step();
    jumpReg = 1'b1;
    registerS1 = target;
    step();
    clear_ctrl();
  endtask

  // Fetch one word and execute it with the given controls already set by the caller.
  task automatic fetch_exec(input logic [31:0] word);
    logic b_z, b_nz, j, jr, zf, nzf;
    {b_z, b_nz, j, jr, zf, nzf} = {branchZ, branchNZ, jump, jumpReg, zFlag, nzFlag};
    clear_ctrl();
    imemReady = 1'b1;
    imemRdata = word;
    step();
    {branchZ, branchNZ, jump, jumpReg, zFlag, nzFlag} = {b_z, b_nz, j, jr, zf, nzf};
    step();
    clear_ctrl();
  endtask

  initial begin
    logic [5:0]  op;
    logic [15:0] imm16;

    clear_ctrl();
    imemReady = 1'b0; imemRdata = '0; extendedImm = '0; registerS1 = '0;
    apply_reset();

    // 1: reset held three cycles, then sequential fetch
    repeat (3) step();
    check("rst_addr", imemAddr, 32'h0);
    check("rst_req",  {31'b0, imemReq}, 32'h0);
    check("rst_end",  {31'b0, endProgram}, 32'h0);
    reset = 1'b1;
    imemReady = 1'b1;
    imemRdata = 32'h2001_0005;
    step();
    check("t1_valid0", {31'b0, instrValid}, 32'h1);
    check("t1_instr0", instr, 32'h2001_0005);
    check("t1_pp4_0",  pcPlus4, 32'h4);
    step();
    check("t1_addr4",  imemAddr, 32'h4);
    check("t1_valid_pulse", {31'b0, instrValid}, 32'h0);
    imemRdata = 32'h2002_0007;
    step();
    check("t1_pp4_1",  pcPlus4, 32'h8);
    step();
    check("t1_addr8",  imemAddr, 32'h8);

    // 2: five wait states then ready
    imemReady = 1'b0;
    repeat (5) begin
      step();
      check("t2_req_held", {31'b0, imemReq}, 32'h1);
      check("t2_addr_stable", imemAddr, 32'h8);
    end
    imemReady = 1'b1;
    step();
    check("t2_exec_next", {31'b0, instrValid}, 32'h1);
    step();

    // 3: branches from 0x40 with a -16 offset
    extendedImm = 32'hFFFF_FFF0;
    goto_pc(32'h40);
    branchZ = 1'b1; zFlag = 1'b1;
    fetch_exec(32'h1000_0000);
    check("t3_beqz_taken", imemAddr, 32'h34);
    goto_pc(32'h40);
    branchZ = 1'b1; zFlag = 1'b0; nzFlag = 1'b1;
    fetch_exec(32'h1000_0000);
    check("t3_beqz_not", imemAddr, 32'h44);
    goto_pc(32'h40);
    branchNZ = 1'b1; nzFlag = 1'b1;
    fetch_exec(32'h1400_0000);
    check("t3_bnez_taken", imemAddr, 32'h34);

    // 4: priority and wrap-around
    registerS1 = 32'h103;
    jumpReg = 1'b1; jump = 1'b1; branchZ = 1'b1; zFlag = 1'b1;
    fetch_exec(32'h0800_0040);
    check("t4_priority", imemAddr, 32'h100);
    goto_pc(32'hFFFF_FFFC);
    check("t4_pp4_wrap", pcPlus4, 32'h0);
    fetch_exec(32'h2000_0000);
    check("t4_wrap", imemAddr, 32'h0);

    // 5: backward jump
    goto_pc(32'h10);
    jump = 1'b1;
    fetch_exec({6'h02, 26'h3FF_FFF8});
    check("t5_jump", imemAddr, 32'h0C);

    // 6: halt, then asynchronous reset in the middle of a FETCH
    imemReady = 1'b1;
    imemRdata = 32'h4400_0000;
    step();
    check("t6_end_rise", {31'b0, endProgram}, 32'h1);
    check("t6_no_valid", {31'b0, instrValid}, 32'h0);
    repeat (3) begin
      step();
      check("t6_req_low", {31'b0, imemReq}, 32'h0);
      check("t6_pc_frozen", imemAddr, 32'h0C);
    end
    apply_reset();
    step();
    reset = 1'b1;
    goto_pc(32'h20);
    imemReady = 1'b0;
    step();
    #2;
    apply_reset();
    #1;
    check("t6_async_req", {31'b0, imemReq}, 32'h0);
    check("t6_async_pc",  imemAddr, 32'h0);
    check("t6_async_end", {31'b0, endProgram}, 32'h0);
    step();
    reset = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      imemReady = ($urandom_range(0, 3) != 0);
      op = 6'($urandom_range(0, 63));
      if (op == HALT_OP && $urandom_range(0, 3) != 0) op = 6'h00;
      imemRdata = {op, 26'($urandom)};
      jumpReg  = ($urandom_range(0, 7) == 0);
      jump     = ($urandom_range(0, 5) == 0);
      branchZ  = ($urandom_range(0, 3) == 0);
      branchNZ = ($urandom_range(0, 3) == 0);
      zFlag    = 1'($urandom);
      nzFlag   = ($urandom_range(0, 3) == 0) ? zFlag : ~zFlag;
      registerS1 = $urandom;
      imm16 = 16'($urandom);
      extendedImm = {{16{imm16[15]}}, imm16};
      if (m_phase == PH_HALT && $urandom_range(0, 3) == 0) apply_reset();
      else reset = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
